// File: rtl/ah_credit_rx_fifo.sv
// Credit-returning receive FIFO behind the narrow-to-wide converter; optional overflow flag via AH_CREDIT_RX_OVF_CHK_EN.
// Latency: push visible on out_data the cycle after the push edge; credit pulse the cycle after each pop.
// Backpressure: none upstream (space guaranteed by credits); consumer throttles via out_ready.
module ah_credit_rx_fifo #(
    parameter int DATA_W = 15,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rstn,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_credit,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready
`ifdef AH_CREDIT_RX_OVF_CHK_EN
    ,
    output logic              err_overflow
`endif
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH + 1);

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic [PTR_W-1:0]  r_wr_ptr;
    logic [PTR_W-1:0]  r_rd_ptr;
    logic [CNT_W-1:0]  r_count;
    logic              r_credit;

    logic w_full;
    logic w_pop;
    logic w_push;

    assign out_valid = (r_count != '0);
    assign out_data  = r_mem[r_rd_ptr];
    assign in_credit = r_credit;

    assign w_full = (r_count == CNT_W'(DEPTH));
    assign w_pop  = out_valid & out_ready;
    // A pop in the same cycle frees the head slot, so a push into a full FIFO is legal then.
    assign w_push = in_valid & (~w_full | w_pop);

    // Storage is intentionally not reset; out_valid guards its contents.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_credit <= 1'b0;
        end else begin
            r_credit <= w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

`ifdef AH_CREDIT_RX_OVF_CHK_EN
    logic w_ovf;
    logic r_err_overflow;

    assign w_ovf        = in_valid & w_full & ~w_pop;
    assign err_overflow = r_err_overflow;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_err_overflow <= 1'b0;
        end else if (w_ovf) begin
            r_err_overflow <= 1'b1;
        end
    end

`ifndef SYNTHESIS
    always @(posedge clk) begin
        if (rstn && w_ovf) begin
            $error("ah_credit_rx_fifo: push while full without pop, word dropped");
        end
    end
`endif
`endif

endmodule

// File: doc/ah_credit_rx_fifo.md
# ah_credit_rx_fifo

Credit-based receive buffer downstream of the narrow-to-wide packet converter. Accepts each collated wide word (valid-only, no back-pressure), stores it in a DEPTH-entry FIFO and presents it to the consumer over a valid/ready handshake. It returns one credit pulse per word consumed, so the upstream converter's credit counter never overruns the buffer.

## Interface
- DATA_W, 15, width of a collated word
- DEPTH, 4, FIFO entries; power of two, ≥ 2; equals the credits the upstream sender holds after reset
- clk  input  1  clock; all state on rising edge
- rstn  input  1  asynchronous, active-low reset
- in_data  input  DATA_W  word from upstream converter
- in_valid  input  1  push strobe; no ready, space guaranteed by credits
- in_credit  output  1  one-cycle credit return pulse, wired to upstream wcredit
- out_data  output  DATA_W  head-of-FIFO word
- out_valid  output  1  FIFO non-empty
- out_ready  input  1  consumer accepts head word
- err_overflow  output  1  sticky overflow flag (only with AH_CREDIT_RX_OVF_CHK_EN)

## Operation
- Storage: DEPTH x DATA_W register array, wr_ptr and rd_ptr of clog2(DEPTH) bits, wrap naturally at DEPTH-1 -> 0; occupancy count of clog2(DEPTH+1) bits.
- Push: in_valid=1 and (count<DEPTH or pop same cycle) -> mem[wr_ptr]<=in_data, wr_ptr+1.
- Pop: out_valid && out_ready -> rd_ptr+1.
- count: +1 on push only, -1 on pop only, unchanged on both or neither.
- out_valid = (count != 0); out_data = mem[rd_ptr] (combinational read of registered storage, no extra register).
- in_credit: registered; asserted the cycle after every pop, exactly one pulse per popped word; back-to-back pops give back-to-back pulses.
- Push while full with simultaneous pop: legal; incoming word stored in freed slot, count stays DEPTH.
- Push while full without pop: overflow; word dropped, pointers and count unchanged.
- out_ready while empty: ignored, no credit issued.
- No state machine beyond pointers/count/credit register.

## Timing
- Reset (asynchronous, rstn low): wr_ptr=rd_ptr=0, count=0, out_valid=0, in_credit=0, err_overflow=0; out_data undefined until first push (array not reset). Reset mid-operation discards all contents and drops any pending credit pulse.
- Push-to-visible latency: word pushed at edge N is on out_data with out_valid=1 in the cycle after edge N.
- Pop-to-credit latency: pop sampled at edge N -> in_credit=1 for the cycle after edge N, low after edge N+1 unless another pop.
- Throughput: one push and one pop per cycle sustained at any occupancy.
- Upstream must not push more than DEPTH words beyond credits returned; credit loop round-trip is pop + 1 cycle.

## Configuration
- AH_CREDIT_RX_OVF_CHK_EN defined: port err_overflow present; set to 1 on the edge after an overflow push, held until rstn low; also fires a simulation-only $error message.
- Undefined: err_overflow port and its logic absent; overflow pushes are silently dropped exactly as above.

## Test plan
- Reset then idle: out_valid=0, in_credit=0, err_overflow=0 for 10 cycles.
- Push 0x1A5 with out_ready=0 -> next cycle out_valid=1, out_data=0x1A5; raise out_ready -> pop, in_credit=1 exactly one cycle later, out_valid=0.
- DEPTH=4: push 0x001..0x004 back-to-back, out_ready=0 -> count=4; then out_ready=1 for 4 cycles -> out_data 0x001,0x002,0x003,0x004 in order, 4 consecutive credit pulses each one cycle after its pop.
- Full FIFO, push 0x7FF with simultaneous pop -> head 0x001 leaves, 0x7FF stored at tail, out_valid stays 1, err_overflow=0.
- Full FIFO, push 0x555 with out_ready=0 (macro on) -> word dropped, err_overflow=1 next cycle and sticky; drain yields original 4 words only.
- Continuous push+pop for 20 cycles with pointer wrap, then rstn low mid-stream -> out_valid and in_credit low immediately, count 0 after release.
